// File: rtl/axi4_rd_mem_slave_if.sv
// AXI4 read-channel pair (AR + R) shared by the DMA read engine and the memory slave.
interface AXI4ReadIntf #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } RdAddrT;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } RdDataT;

    RdAddrT RdAddrPayload;
    logic   RdAddrValid;
    logic   RdAddrReady;
    RdDataT RdDataPayload;
    logic   RdDataValid;
    logic   RdDataReady;

    modport Master (
        output RdAddrPayload, RdAddrValid, RdDataReady,
        input  RdAddrReady, RdDataPayload, RdDataValid
    );

    modport Slave (
        input  RdAddrPayload, RdAddrValid, RdDataReady,
        output RdAddrReady, RdDataPayload, RdDataValid
    );
endinterface

// File: rtl/axi4_rd_mem_slave.sv
// AXI4 read slave serving one burst at a time from a 1-cycle-latency SRAM,
// with a 2-entry output buffer so R beats stream at full rate under backpressure.
module axi4_rd_mem_slave #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 12,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    AXI4ReadIntf.Slave            axi,
    output logic                  MemRdEn,
    output logic [MEM_AW-1:0]     MemRdAddr,
    input  logic [DATA_WIDTH-1:0] MemRdData
);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int EW  = DATA_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, BURST} stateT;

    stateT                 state, stateNext;
    logic                  rstDone;
    logic [ID_WIDTH-1:0]   burstId;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [7:0]            burstLen;
    logic [2:0]            burstSize;
    logic [1:0]            burstType;
    logic                  errFlag;
    logic [8:0]            remaining;
    logic                  inflight, inflightLast;
    logic [EW-1:0]         entry0, entry1;
    logic [1:0]            fifoCount;

    logic                  arReady, arFire, arErr;
    logic                  pop, push, issue, errPush, lastAccepted;
    logic [2:0]            occ;
    logic [EW-1:0]         pushEntry;
    logic [ADDR_WIDTH-1:0] beatBytes, incrNext, wrapSpan, wrapBase, wrapNext, addrNext;
    logic [2:0]            wrapLog;

    assign axi.RdAddrReady   = arReady;
    assign axi.RdDataValid   = (fifoCount != 2'd0);
    assign axi.RdDataPayload = {burstId, entry0};
    assign MemRdAddr         = curAddr[OFF+MEM_AW-1:OFF];

    assign arFire       = axi.RdAddrValid && arReady;
    assign pop          = axi.RdDataValid && axi.RdDataReady;
    assign lastAccepted = pop && entry0[0];

    // Reads in flight count against buffer space, but a beat leaving this cycle frees its slot.
    assign occ     = 3'(fifoCount) + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (state == BURST) && (remaining != 9'd0) && (occ < 3'd2);
    assign MemRdEn = issue && !errFlag;
    assign errPush = issue && errFlag;
    assign push    = inflight || errPush;

    always_comb begin
        pushEntry = {MemRdData, 2'b00, inflightLast};
        if (errPush) begin
            pushEntry = {{DATA_WIDTH{1'b0}}, 2'b10, (remaining == 9'd1)};
        end
    end

    always_comb begin
        arErr = 1'b0;
        if (axi.RdAddrPayload.size > 3'(OFF)) begin
            arErr = 1'b1;
        end
        if (axi.RdAddrPayload.burst == 2'b11) begin
            arErr = 1'b1;
        end
        if (axi.RdAddrPayload.burst == 2'b10 &&
            !(axi.RdAddrPayload.len == 8'd1 || axi.RdAddrPayload.len == 8'd3 ||
              axi.RdAddrPayload.len == 8'd7 || axi.RdAddrPayload.len == 8'd15)) begin
            arErr = 1'b1;
        end
    end

    // Wrap span is (len+1)*B; len is restricted to 2^n-1, so it becomes a shift.
    always_comb begin
        beatBytes = ONE << burstSize;
        wrapLog   = 3'd0;
        case (burstLen)
            8'd1:    wrapLog = 3'd1;
            8'd3:    wrapLog = 3'd2;
            8'd7:    wrapLog = 3'd3;
            8'd15:   wrapLog = 3'd4;
            default: wrapLog = 3'd0;
        endcase
        incrNext = (curAddr & ~(beatBytes - ONE)) + beatBytes;
        wrapSpan = beatBytes << wrapLog;
        wrapBase = curAddr & ~(wrapSpan - ONE);
        wrapNext = wrapBase + ((curAddr + beatBytes - wrapBase) & (wrapSpan - ONE));
        case (burstType)
            2'b01:   addrNext = incrNext;
            2'b10:   addrNext = wrapNext;
            default: addrNext = curAddr;
        endcase
    end

    always_comb begin
        stateNext = state;
        arReady   = 1'b0;
        case (state)
            IDLE: begin
                arReady = rstDone;
                if (axi.RdAddrValid && rstDone) begin
                    stateNext = BURST;
                end
            end
            BURST: begin
                if (lastAccepted) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstDone      <= 1'b0;
            burstId      <= '0;
            curAddr      <= '0;
            burstLen     <= '0;
            burstSize    <= '0;
            burstType    <= '0;
            errFlag      <= 1'b0;
            remaining    <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
            entry0       <= '0;
            entry1       <= '0;
            fifoCount    <= '0;
        end else begin
            rstDone      <= 1'b1;
            inflight     <= MemRdEn;
            inflightLast <= (remaining == 9'd1);
            if (arFire) begin
                burstId   <= axi.RdAddrPayload.id;
                curAddr   <= axi.RdAddrPayload.addr;
                burstLen  <= axi.RdAddrPayload.len;
                burstSize <= axi.RdAddrPayload.size;
                burstType <= axi.RdAddrPayload.burst;
                errFlag   <= arErr;
                remaining <= {1'b0, axi.RdAddrPayload.len} + 9'd1;
            end
            if (issue) begin
                remaining <= remaining - 9'd1;
                curAddr   <= addrNext;
            end
            // Entry 0 is always the presented head; entry 1 is the skid slot.
            case ({push, pop})
                2'b10: begin
                    if (fifoCount == 2'd0) begin
                        entry0 <= pushEntry;
                    end else begin
                        entry1 <= pushEntry;
                    end
                    fifoCount <= fifoCount + 2'd1;
                end
                2'b01: begin
                    entry0    <= entry1;
                    fifoCount <= fifoCount - 2'd1;
                end
                2'b11: begin
                    if (fifoCount == 2'd1) begin
                        entry0 <= pushEntry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= pushEntry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_rd_mem_slave.sv
// Bench for axi4_rd_mem_slave: directed and random bursts against a burst-level
// address/response model and a behavioural SRAM.
module tb_axi4_rd_mem_slave;
    localparam int DW   = 64;
    localparam int IW   = 4;
    localparam int AW   = 12;
    localparam int ADW  = 32;
    localparam int OFFB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI4ReadIntf #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .ADDR_WIDTH(ADW)) axiBus ();

    logic          memRdEn;
    logic [AW-1:0] memRdAddr;
    logic [DW-1:0] memRdData;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    axi4_rd_mem_slave #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(AW), .ADDR_WIDTH(ADW)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axiBus),
        .MemRdEn   (memRdEn),
        .MemRdAddr (memRdAddr),
        .MemRdData (memRdData)
    );

    // Single-port synchronous SRAM, one cycle of read latency.
    always @(posedge clk) begin
        if (memRdEn) memRdData <= mem[memRdAddr];
    end

    int checks   = 0;
    int failures = 0;
    int stallPattern [6] = '{1, 0, 0, 1, 0, 1};

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one complete burst and checks every R beat against the model.
    task automatic applyStimulus(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input int readyMode,
                                 input string name);
        logic            err;
        longint unsigned a, bb, w, base;
        logic [AW-1:0]   words [$];
        int              nBeats, n, k, issued, accepted, firstK, lastK, maxOut;
        logic            ready, stallValid, rdEnInErr;
        logic [127:0]    heldPayload;

        err = (size > 3'(OFFB)) || (burst == 2'b11) ||
              (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        nBeats = int'(len) + 1;
        bb     = 64'd1 << size;
        a      = 64'(addr);
        for (int i = 0; i < nBeats; i++) begin
            words.push_back(AW'(a >> OFFB));
            if (burst == 2'b01) begin
                a = (a / bb) * bb + bb;
            end else if (burst == 2'b10) begin
                w    = 64'(nBeats) * bb;
                base = (a / w) * w;
                a    = base + ((a + bb - base) % w);
            end
        end

        @(negedge clk);
        axiBus.RdAddrValid   = 1'b1;
        axiBus.RdAddrPayload = {id, addr, len, size, burst};
        n = 0;
        while (!axiBus.RdAddrReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkOutput({name, " arTimeout"}, 0, 1);
            axiBus.RdAddrValid = 1'b0;
            return;
        end
        @(negedge clk);
        axiBus.RdAddrValid   = 1'b0;
        axiBus.RdAddrPayload = 49'({$urandom, $urandom});

        k = 1; issued = 0; accepted = 0; firstK = -1; lastK = -1; maxOut = 0;
        stallValid = 1'b0; rdEnInErr = 1'b0; heldPayload = '0;
        while (accepted < nBeats && k < 400) begin
            if (readyMode == 0)      ready = 1'b1;
            else if (readyMode == 1) ready = stallPattern[(k - 1) % 6] != 0;
            else                     ready = 1'($urandom_range(0, 1));
            axiBus.RdDataReady = ready;
            #1;
            if (memRdEn) begin
                if (err) rdEnInErr = 1'b1;
                else begin
                    if (issued < nBeats) checkOutput({name, " memAddr"}, memRdAddr, words[issued]);
                    issued++;
                end
            end
            if (axiBus.RdDataValid) begin
                if (firstK < 0) begin
                    firstK = k;
                    checkOutput({name, " latency"}, firstK, err ? 2 : 3);
                end
                if (stallValid) checkOutput({name, " stable"}, axiBus.RdDataPayload, heldPayload);
                if (ready) begin
                    checkOutput({name, " id"}, axiBus.RdDataPayload.id, id);
                    checkOutput({name, " data"}, axiBus.RdDataPayload.data, err ? '0 : mem[words[accepted]]);
                    checkOutput({name, " resp"}, axiBus.RdDataPayload.resp, err ? 2'b10 : 2'b00);
                    checkOutput({name, " last"}, axiBus.RdDataPayload.last, accepted == nBeats - 1);
                    accepted++;
                    lastK      = k;
                    stallValid = 1'b0;
                end else begin
                    stallValid  = 1'b1;
                    heldPayload = 128'(axiBus.RdDataPayload);
                end
            end else if (stallValid) begin
                checkOutput({name, " validHeld"}, 0, 1);
                stallValid = 1'b0;
            end
            if (!err && issued - accepted > maxOut) maxOut = issued - accepted;
            @(negedge clk);
            k++;
        end
        axiBus.RdDataReady = 1'b0;
        #1;
        checkOutput({name, " beats"}, accepted, nBeats);
        checkOutput({name, " reads"}, issued, err ? 0 : nBeats);
        checkOutput({name, " rdEnInErr"}, rdEnInErr, 0);
        checkOutput({name, " maxOut"}, maxOut <= 2, 1);
        checkOutput({name, " idleAgain"}, axiBus.RdAddrReady, 1);
        checkOutput({name, " drained"}, axiBus.RdDataValid, 0);
        if (readyMode == 0) checkOutput({name, " noBubble"}, lastK - firstK, nBeats - 1);
    endtask

    initial begin
        int acc, k;
        logic [1:0] rb;
        logic [7:0] rl;
        logic [3:0] lenSet [4] = '{4'd1, 4'd3, 4'd7, 4'd15};

        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        axiBus.RdAddrValid   = 1'b0;
        axiBus.RdAddrPayload = '0;
        axiBus.RdDataReady   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst arReady", axiBus.RdAddrReady, 0);
        checkOutput("rst rValid", axiBus.RdDataValid, 0);
        checkOutput("rst payload", axiBus.RdDataPayload, 0);
        checkOutput("rst memRdEn", memRdEn, 0);
        checkOutput("rst memRdAddr", memRdAddr, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst arReady", axiBus.RdAddrReady, 1);

        applyStimulus(4'h5, 32'h100, 8'd3, 3'd3, 2'b01, 0, "incr");
        applyStimulus(4'h6, 32'h118, 8'd3, 3'd3, 2'b10, 0, "wrap");
        applyStimulus(4'h7, 32'h40,  8'd2, 3'd3, 2'b00, 0, "fixed");
        applyStimulus(4'h8, 32'h300, 8'd7, 3'd3, 2'b01, 1, "stall");
        applyStimulus(4'h9, 32'h80,  8'd1, 3'd4, 2'b01, 0, "errSize");
        applyStimulus(4'hA, 32'h80,  8'd1, 3'd3, 2'b11, 1, "errBurst");
        applyStimulus(4'hB, 32'h80,  8'd2, 3'd3, 2'b10, 0, "errWrapLen");
        applyStimulus(4'hC, 32'h7FF8, 8'd3, 3'd3, 2'b01, 0, "incrMemWrap");

        // Reset while beat 2 of an 8-beat burst is being presented.
        @(negedge clk);
        axiBus.RdAddrValid   = 1'b1;
        axiBus.RdAddrPayload = {4'hD, 32'h200, 8'd7, 3'd3, 2'b01};
        k = 0;
        while (!axiBus.RdAddrReady && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        axiBus.RdAddrValid = 1'b0;
        axiBus.RdDataReady = 1'b1;
        acc = 0;
        k   = 0;
        while (acc < 1 && k < 50) begin
            #1;
            if (axiBus.RdDataValid) acc++;
            @(negedge clk);
            k++;
        end
        checkOutput("midRst beat1", acc, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRst rValid", axiBus.RdDataValid, 0);
        checkOutput("midRst memRdEn", memRdEn, 0);
        checkOutput("midRst arReady", axiBus.RdAddrReady, 0);
        rst = 1'b0;
        axiBus.RdDataReady = 1'b0;
        @(negedge clk);
        checkOutput("midRst arReadyAfter", axiBus.RdAddrReady, 1);
        applyStimulus(4'hE, 32'h1238, 8'd0, 3'd3, 2'b01, 0, "afterRst");

        for (int t = 0; t < 40; t++) begin
            rb = 2'($urandom_range(0, 3));
            if (rb == 2'b10 && $urandom_range(0, 3) != 0) rl = 8'(lenSet[$urandom_range(0, 3)]);
            else                                          rl = 8'($urandom_range(0, 15));
            applyStimulus(4'($urandom), $urandom, rl, 3'($urandom_range(0, 4)), rb,
                          int'($urandom_range(0, 2)), "rand");
        end

        $display("[TB] stimulus complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_rd_mem_slave.md
Name: axi4_rd_mem_slave

Overview:
- Responder end of the AXI4 read channel pair: binds to AXI4ReadIntf through its Slave modport, accepts AR requests and returns R beats.
- Data is served from an external single-port synchronous SRAM with 1-cycle read latency.
- Used as the memory model and as the on-chip buffer front-end that the DMA read engine (Master modport) talks to.
- One burst outstanding at a time; full R throughput (1 beat/cycle) when RdDataReady is held high.

Parameters:
- DATA_WIDTH, 64, R data width in bits; power of 2, 32..512.
- ID_WIDTH, 4, AXI ID width.
- MEM_AW, 12, SRAM word-address width.
- OFF (localparam), log2(DATA_WIDTH/8), byte-offset bits of the address.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- axi  Slave modport of AXI4ReadIntf  -  RdAddrPayload{id, addr, len[7:0], size[2:0], burst[1:0]}, RdAddrValid, RdAddrReady, RdDataPayload{id, data, resp[1:0], last}, RdDataValid, RdDataReady.
- MemRdEn  out  1  SRAM read strobe.
- MemRdAddr  out  MEM_AW  SRAM word address, = addr[OFF+MEM_AW-1:OFF].
- MemRdData  in  DATA_WIDTH  SRAM data, valid the cycle after MemRdEn.

Behaviour:
- Reset values: RdAddrReady=0, RdDataValid=0, RdDataPayload all-zero, MemRdEn=0, MemRdAddr=0.
- In the first cycle after rst deasserts the FSM is in IDLE, so RdAddrReady=1 from then on.
- Reset mid-burst aborts the burst immediately. No further R beats are produced, and the output buffer and in-flight read are discarded.
- FSM states: IDLE, BURST.
- IDLE:
  - RdAddrReady=1.
  - On RdAddrValid&&RdAddrReady, latch id/addr/len/size/burst, load beat counter = len, compute the error flag, then go to BURST.
- BURST:
  - RdAddrReady=0.
  - Issue one SRAM read per beat. Return to IDLE in the cycle the beat with last=1 is accepted (RdDataValid&&RdDataReady).
  - The next AR may be accepted in the following cycle.
- Error flag: set when any of the following holds. When set, all len+1 beats return resp=SLVERR (2'b10), data=0, and MemRdEn stays 0.
  - size > OFF.
  - burst == 2'b11 (reserved).
  - burst == WRAP with len not in {1, 3, 7, 15}.
- Otherwise resp=OKAY (2'b00).
- Address sequence, with B = 1<<size:
  - FIXED: address constant for every beat.
  - INCR: next = (addr & ~(B-1)) + B. The first beat may be unaligned. 4KB crossing is not checked; the SRAM address wraps modulo 2^MEM_AW words.
  - WRAP: span W = (len+1)*B, base = addr & ~(W-1), next = base + ((addr + B - base) mod W).
- Narrow transfers (size < OFF): data is the full SRAM word, unshifted; the master selects lanes.
- Output buffering: 2-entry output FIFO (skid) feeds RdDataPayload/RdDataValid.
  - A new SRAM read is issued only when (entries occupied + reads in flight) < 2. This guarantees no overflow under backpressure.
  - When RdDataReady is held high, beats flow back-to-back with no bubble.
  - When RdDataReady is held low, RdDataValid stays 1 and the payload is stable until accepted (AXI rule). No beat is dropped or duplicated.
- Latency: AR handshake at cycle T gives MemRdEn at T+1 and the first RdDataValid at T+3 (data registered into the FIFO). Error bursts present their first beat at T+2.
- Per-beat fields: RdDataPayload.id = latched id for every beat; last=1 only on beat len (the counter reaches 0).
- len=0 produces a single beat with last=1.
- RdAddrValid asserted while in BURST is ignored until IDLE, and the payload is not sampled.

Test Plan:
- INCR, addr=0x100, len=3, size=3, SRAM[w]=w, ready=1 -> MemRdAddr 0x20..0x23; 4 beats data 0x20..0x23 on consecutive cycles; last only on beat 4; resp=OKAY; id echoed.
- WRAP, addr=0x118, len=3, size=3 -> word addresses 0x23, 0x20, 0x21, 0x22; last on the 4th beat.
- FIXED, addr=0x40, len=2 -> three beats all from word 0x08.
- RdDataReady toggled 1,0,0,1,0,1... during INCR len=7 -> exactly 8 beats in order, payload stable while stalled, never more than 2 reads outstanding/buffered.
- Error cases: size=4 with DATA_WIDTH=64, len=1 -> 2 beats SLVERR, data=0, MemRdEn never asserted. burst=2'b11 -> same. WRAP len=2 -> same.
- rst asserted during beat 2 of a len=7 burst -> next cycle RdDataValid=0, MemRdEn=0. After release, a new AR len=0 returns a single correct beat with last=1.
